unpool_upsample: RTL and testbench
==================================

Name: unpool_upsample

Overview:
- 2x nearest-neighbour upsampler, the inverse data path of the 2x2/stride-2 max-pooling stage.
- Reads a square source feature map of matrix x matrix pixels from pixel memory.
- Writes each pixel as a 2x2 block into a (2*matrix) x (2*matrix) destination map.
- Used in decoder/upsampling layers; shares the pixel-memory read/write port style and enable/STOP handshake of the other layer engines.

Parameters:
- SIZE_1, 11, pixel data width (signed).
- SIZE_address_pix, 13, pixel memory address width.

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- unpool_en  input  1  level enable; high = run, low = abort/idle.
- memstartp  input  SIZE_address_pix  source map base address.
- memstartzap  input  SIZE_address_pix  destination map base address.
- matrix  input  5  source map side length (0..31).
- read_addressp  output  SIZE_address_pix  source read address (registered).
- re  output  1  read enable (registered).
- qp  input  SIZE_1  signed read data.
- write_addressp  output  SIZE_address_pix  destination write address (registered).
- we  output  1  write enable (registered).
- dp  output  SIZE_1  signed write data (registered).
- STOP  output  1  done flag, held high until unpool_en falls.

Behaviour:
- Reset (rst_n low, async): read_addressp=0, re=0, write_addressp=0, we=0, dp=0, STOP=0, row r=0, col c=0, state IDLE.
- Memory read timing: qp sampled at edge E+2 reflects the address registered at edge E.
- States: IDLE, RD, WT, WR0, WR1, WR2, WR3, DONE.
- IDLE: if unpool_en=1 and matrix=0 -> DONE. If unpool_en=1 and matrix!=0 -> RD, registering read_addressp=memstartp+r*matrix+c and re=1.
- RD -> WT unconditionally; re=0.
- WT -> WR0; pixel buffer <= qp on this edge.
- WRk (k=0..3) is entered with we=1, dp=buffer, and write_addressp = base + off_k.
  - base = memstartzap + (2r)*(2*matrix) + 2c.
  - off_0=0, off_1=1, off_2=2*matrix, off_3=2*matrix+1.
- WR3 exit:
  - we=0.
  - If c!=matrix-1: c=c+1, next RD.
  - Else if r!=matrix-1: c=0, r=r+1, next RD.
  - Else: DONE.
- Each RD entry registers the new read address and re=1. Each pixel costs 6 cycles.
- DONE: STOP=1, re=0, we=0; stays in DONE while unpool_en=1.
- unpool_en low in any state: next edge -> IDLE, STOP=0, re=0, we=0, r=c=0. Any in-flight pixel is discarded with no further writes. This is a synchronous abort, distinct from async reset.
- Address arithmetic:
  - Computed at SIZE_address_pix width, unsigned, wrapping modulo 2^SIZE_address_pix.
  - matrix is zero-extended.
  - Products are truncated, not saturated.
- Data is passed unchanged (no sign/width conversion).
- matrix, memstartp and memstartzap must be stable while unpool_en=1. They are sampled combinationally each cycle, not latched.
- Writes occur only in WR0..WR3; at most one of re/we is high in any cycle.

Optional Feature:
- Macro UNPOOL_ZERO_FILL_EN.
- Defined: zero-insertion upsampling. WR0 writes the pixel value; WR1..WR3 write dp=0 (we still 1, same addresses and timing).
- Undefined: all four writes carry the pixel value (nearest-neighbour replication).

Test Plan:
- Replication: matrix=2, memstartp=100, memstartzap=200, source [5,-3,7,0], unpool_en held high.
  - Writes: 200,201,204,205=5; 202,203,206,207=-3; 208,209,212,213=7; 210,211,214,215=0.
  - Exactly 16 we pulses; STOP rises after 24 active cycles and holds.
- Zero fill (UNPOOL_ZERO_FILL_EN defined), same stimulus: 200=5, 202=-3, 208=7, 210=0; all other 12 writes dp=0.
- Boundaries:
  - matrix=1, source 0x3FF at memstartp=0 -> 4 writes to memstartzap+{0,1,2,3} = 0x3FF, then STOP.
  - matrix=0 -> STOP next edge, no re/we pulses.
- Abort: drop unpool_en in WR1 of pixel 2 (matrix=3) -> next edge we=0, STOP=0, IDLE. Re-raise -> restarts from r=0,c=0 at memstartp.
- Async reset: assert rst_n low mid-WR2 between clock edges -> outputs 0 immediately, no further writes until rst_n high and unpool_en reasserted.
- Address wrap: memstartzap=8190, matrix=1 -> writes to 8190, 8191, 0, 1.

Source files
------------

// File: rtl/unpool_upsample.sv
// 2x upsampler: each source pixel is written as a 2x2 block of the destination map.
// Define UNPOOL_ZERO_FILL_EN to zero the three non-anchor pixels of each block.
`timescale 1ns/1ps

module unpool_upsample #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_address_pix = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        unpool_en,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_address_pix-1:0] memstartzap,
    input  logic [4:0]                  matrix,
    output logic [SIZE_address_pix-1:0] read_addressp,
    output logic                        re,
    input  logic signed [SIZE_1-1:0]    qp,
    output logic [SIZE_address_pix-1:0] write_addressp,
    output logic                        we,
    output logic signed [SIZE_1-1:0]    dp,
    output logic                        STOP
);

    localparam int AW = SIZE_address_pix;

`ifdef UNPOOL_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WT,
        WR0,
        WR1,
        WR2,
        WR3,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [4:0] r_q, r_d;
    logic [4:0] c_q, c_d;
    logic [4:0] nr, nc;
    logic       last_c, last_r;

    logic signed [SIZE_1-1:0] pix_q, pix_d;
    logic signed [SIZE_1-1:0] fill;
    logic signed [SIZE_1-1:0] dp_d;

    logic [AW-1:0] rd_addr_d, wr_addr_d;
    logic          re_d, we_d, stop_d;

    logic [AW-1:0] m_ext, m2;
    logic [AW-1:0] base;
    logic [AW-1:0] rd_next;

    // All arithmetic is modulo 2^AW; matrix and row/col are zero-extended.
    assign m_ext = AW'(matrix);
    assign m2    = m_ext << 1;
    assign base  = memstartzap
                 + ((AW'(r_q) * m_ext) << 2)
                 + (AW'(c_q) << 1);

    assign last_c = (c_q == matrix - 5'd1);
    assign last_r = (r_q == matrix - 5'd1);
    assign nc     = last_c ? 5'd0 : c_q + 5'd1;
    assign nr     = last_c ? r_q + 5'd1 : r_q;

    assign rd_next = memstartp + AW'(nr) * m_ext + AW'(nc);

    assign fill = ZERO_FILL ? '0 : pix_q;

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        pix_d     = pix_q;
        rd_addr_d = read_addressp;
        wr_addr_d = write_addressp;
        dp_d      = dp;
        re_d      = 1'b0;
        we_d      = 1'b0;
        stop_d    = 1'b0;

        if (!unpool_en) begin
            state_d = IDLE;
            r_d     = '0;
            c_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (matrix == 5'd0) begin
                        state_d = DONE;
                        stop_d  = 1'b1;
                    end else begin
                        // row/col are always zero here
                        state_d   = RD;
                        re_d      = 1'b1;
                        rd_addr_d = memstartp;
                    end
                end
                RD: begin
                    state_d = WT;
                end
                WT: begin
                    // read data lands this edge; forward it straight to the first write
                    state_d   = WR0;
                    pix_d     = qp;
                    we_d      = 1'b1;
                    dp_d      = qp;
                    wr_addr_d = base;
                end
                WR0: begin
                    state_d   = WR1;
                    we_d      = 1'b1;
                    dp_d      = fill;
                    wr_addr_d = base + AW'(1);
                end
                WR1: begin
                    state_d   = WR2;
                    we_d      = 1'b1;
                    dp_d      = fill;
                    wr_addr_d = base + m2;
                end
                WR2: begin
                    state_d   = WR3;
                    we_d      = 1'b1;
                    dp_d      = fill;
                    wr_addr_d = base + m2 + AW'(1);
                end
                WR3: begin
                    if (last_c && last_r) begin
                        state_d = DONE;
                        stop_d  = 1'b1;
                    end else begin
                        state_d   = RD;
                        r_d       = nr;
                        c_d       = nc;
                        re_d      = 1'b1;
                        rd_addr_d = rd_next;
                    end
                end
                DONE: begin
                    stop_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            r_q            <= '0;
            c_q            <= '0;
            pix_q          <= '0;
            read_addressp  <= '0;
            re             <= 1'b0;
            write_addressp <= '0;
            we             <= 1'b0;
            dp             <= '0;
            STOP           <= 1'b0;
        end else begin
            state_q        <= state_d;
            r_q            <= r_d;
            c_q            <= c_d;
            pix_q          <= pix_d;
            read_addressp  <= rd_addr_d;
            re             <= re_d;
            write_addressp <= wr_addr_d;
            we             <= we_d;
            dp             <= dp_d;
            STOP           <= stop_d;
        end
    end

endmodule

// File: tb/tb_unpool_upsample.sv
// Bench for unpool_upsample: random maps against a block-coordinate model.
// Covers reset, fixed vectors, boundaries, abort, async reset and address wrap.
`timescale 1ns/1ps

module tb_unpool_upsample;

    localparam int W  = 11;
    localparam int AW = 13;

`ifdef UNPOOL_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 unpool_en;
    logic [AW-1:0]        memstartp;
    logic [AW-1:0]        memstartzap;
    logic [4:0]           matrix;
    logic [AW-1:0]        read_addressp;
    logic                 re;
    logic signed [W-1:0]  qp;
    logic [AW-1:0]        write_addressp;
    logic                 we;
    logic signed [W-1:0]  dp;
    logic                 STOP;

    logic signed [W-1:0]  mem [0:8191];

    logic [AW-1:0]        wa_q [$];
    logic signed [W-1:0]  wd_q [$];
    logic [AW-1:0]        ea [$];
    logic signed [W-1:0]  ed [$];
    int                   re_cnt;
    int                   both_cnt;

    int checks = 0;
    int errors = 0;

    unpool_upsample #(.SIZE_1(W), .SIZE_address_pix(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .unpool_en(unpool_en),
        .memstartp(memstartp),
        .memstartzap(memstartzap),
        .matrix(matrix),
        .read_addressp(read_addressp),
        .re(re),
        .qp(qp),
        .write_addressp(write_addressp),
        .we(we),
        .dp(dp),
        .STOP(STOP)
    );

    always #5 clk = ~clk;

    // one-cycle synchronous memory: data is valid before the second edge
    always @(posedge clk) qp <= mem[read_addressp];

    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(write_addressp);
            wd_q.push_back(dp);
        end
        if (re) re_cnt++;
        if (re && we) both_cnt++;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        re_cnt   = 0;
        both_cnt = 0;
    endtask

    task automatic fill_src(input logic [AW-1:0] ps, input int n);
        for (int i = 0; i < n; i++)
            mem[AW'(ps + i)] = W'($urandom);
    endtask

    // Destination pixel (2r+dy, 2c+dx) of a 2m-wide map, raster order per block.
    task automatic build_model(input int m, input logic [AW-1:0] ps,
                               input logic [AW-1:0] pz);
        logic signed [W-1:0] v;
        ea.delete();
        ed.delete();
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++) begin
                v = mem[AW'(ps + r * m + c)];
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++) begin
                        ea.push_back(AW'(pz + (2 * r + dy) * (2 * m) + 2 * c + dx));
                        ed.push_back((ZF && (dy != 0 || dx != 0)) ? W'(0) : v);
                    end
            end
    endtask

    task automatic run_to_stop(input int limit, output int edges, output bit to);
        unpool_en = 1'b1;
        edges = 0;
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (STOP) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic go_idle(input int n);
        unpool_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        unpool_en = 1'b0;
        memstartp = '0;
        memstartzap = '0;
        matrix = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({re, we, STOP} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000", {re, we, STOP});
        end
        checks++;
        if (read_addressp !== '0 || write_addressp !== '0 || dp !== '0) begin
            errors++;
            $display("FAIL reset_data: got ra=%0d wa=%0d dp=%0d want 0",
                     read_addressp, write_addressp, dp);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_replicate();
        int edges;
        bit to;
        logic signed [W-1:0] src [4];
        logic [AW-1:0] xa [16];
        logic signed [W-1:0] xv;
        src = '{11'sd5, -11'sd3, 11'sd7, 11'sd0};
        xa = '{200, 201, 204, 205, 202, 203, 206, 207,
               208, 209, 212, 213, 210, 211, 214, 215};
        for (int i = 0; i < 4; i++) mem[100 + i] = src[i];
        matrix = 5'd2;
        memstartp = 13'd100;
        memstartzap = 13'd200;
        clear_log();
        run_to_stop(100, edges, to);
        checks++;
        if (to || edges != 25) begin
            errors++;
            $display("FAIL rep_stop: got edges=%0d timeout=%0d want 25", edges, to);
        end
        checks++;
        if (wa_q.size() != 16) begin
            errors++;
            $display("FAIL rep_count: got %0d want 16", wa_q.size());
        end
        for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
            xv = (ZF && (i % 4) != 0) ? W'(0) : src[i / 4];
            checks++;
            if (wa_q[i] !== xa[i] || wd_q[i] !== xv) begin
                errors++;
                $display("FAIL rep_write%0d: got %0d=%0d want %0d=%0d",
                         i, wa_q[i], wd_q[i], xa[i], xv);
            end
        end
        checks++;
        if (re_cnt != 4 || both_cnt != 0) begin
            errors++;
            $display("FAIL rep_re: got re=%0d overlap=%0d want 4 0", re_cnt, both_cnt);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (STOP !== 1'b1 || wa_q.size() != 16) begin
            errors++;
            $display("FAIL rep_hold: got STOP=%b writes=%0d want 1 16", STOP, wa_q.size());
        end
        go_idle(1);
        checks++;
        if (STOP !== 1'b0) begin
            errors++;
            $display("FAIL rep_release: got STOP=%b want 0", STOP);
        end
        go_idle(1);
    endtask

    task automatic test_random();
        int edges;
        int m;
        bit to;
        for (int it = 0; it < 6; it++) begin
            m = $urandom_range(1, 6);
            matrix = 5'(m);
            memstartp = AW'($urandom);
            memstartzap = AW'($urandom);
            fill_src(memstartp, m * m);
            build_model(m, memstartp, memstartzap);
            clear_log();
            run_to_stop(6 * m * m + 20, edges, to);
            checks++;
            if (to || edges != 6 * m * m + 1) begin
                errors++;
                $display("FAIL rnd%0d_stop: got edges=%0d timeout=%0d want %0d",
                         it, edges, to, 6 * m * m + 1);
            end
            checks++;
            if (wa_q.size() != ea.size() || both_cnt != 0 || re_cnt != m * m) begin
                errors++;
                $display("FAIL rnd%0d_count: got w=%0d re=%0d ov=%0d want %0d %0d 0",
                         it, wa_q.size(), re_cnt, both_cnt, ea.size(), m * m);
            end
            for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
                checks++;
                if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_write%0d: got %0d=%0d want %0d=%0d",
                             it, i, wa_q[i], wd_q[i], ea[i], ed[i]);
                end
            end
            go_idle(2);
        end
    endtask

    task automatic test_boundaries();
        int edges;
        bit to;
        logic signed [W-1:0] xv;
        logic [AW-1:0] wrap [4];
        wrap = '{8190, 8191, 0, 1};
        mem[0] = 11'h3FF;
        matrix = 5'd1;
        memstartp = 13'd0;
        memstartzap = 13'd50;
        clear_log();
        run_to_stop(30, edges, to);
        checks++;
        if (to || edges != 7 || wa_q.size() != 4) begin
            errors++;
            $display("FAIL m1_stop: got edges=%0d w=%0d want 7 4", edges, wa_q.size());
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            xv = (ZF && i != 0) ? W'(0) : 11'h3FF;
            checks++;
            if (wa_q[i] !== AW'(50 + i) || wd_q[i] !== xv) begin
                errors++;
                $display("FAIL m1_write%0d: got %0d=%0d want %0d=%0d",
                         i, wa_q[i], wd_q[i], 50 + i, xv);
            end
        end
        go_idle(2);

        matrix = 5'd0;
        clear_log();
        run_to_stop(10, edges, to);
        checks++;
        if (to || edges != 1 || re_cnt != 0 || wa_q.size() != 0) begin
            errors++;
            $display("FAIL m0: got edges=%0d re=%0d w=%0d want 1 0 0",
                     edges, re_cnt, wa_q.size());
        end
        go_idle(2);

        mem[77] = -11'sd100;
        matrix = 5'd1;
        memstartp = 13'd77;
        memstartzap = 13'd8190;
        clear_log();
        run_to_stop(30, edges, to);
        checks++;
        if (to || wa_q.size() != 4) begin
            errors++;
            $display("FAIL wrap_count: got w=%0d timeout=%0d want 4", wa_q.size(), to);
        end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            xv = (ZF && i != 0) ? W'(0) : -11'sd100;
            checks++;
            if (wa_q[i] !== wrap[i] || wd_q[i] !== xv) begin
                errors++;
                $display("FAIL wrap_write%0d: got %0d=%0d want %0d=%0d",
                         i, wa_q[i], wd_q[i], wrap[i], xv);
            end
        end
        go_idle(2);
    endtask

    task automatic test_abort();
        int edges;
        bit to;
        bit hit;
        matrix = 5'd3;
        memstartp = AW'($urandom);
        memstartzap = AW'($urandom);
        fill_src(memstartp, 9);
        build_model(3, memstartp, memstartzap);
        clear_log();
        unpool_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (wa_q.size() == 10) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_reach: got w=%0d want 10", wa_q.size());
        end
        unpool_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({re, we, STOP} !== 3'b000) begin
            errors++;
            $display("FAIL abort_ctl: got %b want 000", {re, we, STOP});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() != 10) begin
            errors++;
            $display("FAIL abort_writes: got %0d want 10", wa_q.size());
        end
        for (int i = 0; i < 10 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                errors++;
                $display("FAIL abort_pre%0d: got %0d=%0d want %0d=%0d",
                         i, wa_q[i], wd_q[i], ea[i], ed[i]);
            end
        end
        clear_log();
        unpool_en = 1'b1;
        @(negedge clk);
        checks++;
        if (re !== 1'b1 || read_addressp !== memstartp) begin
            errors++;
            $display("FAIL abort_restart: got re=%b ra=%0d want 1 %0d",
                     re, read_addressp, memstartp);
        end
        run_to_stop(80, edges, to);
        checks++;
        if (to || wa_q.size() != 36) begin
            errors++;
            $display("FAIL abort_rerun: got w=%0d timeout=%0d want 36", wa_q.size(), to);
        end
        for (int i = 0; i < 36 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                errors++;
                $display("FAIL abort_rerun%0d: got %0d=%0d want %0d=%0d",
                         i, wa_q[i], wd_q[i], ea[i], ed[i]);
            end
        end
        go_idle(2);
    endtask

    task automatic test_async_reset();
        int edges;
        bit to;
        bit hit;
        matrix = 5'd2;
        memstartp = AW'($urandom);
        memstartzap = AW'($urandom);
        fill_src(memstartp, 4);
        build_model(2, memstartp, memstartzap);
        clear_log();
        unpool_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (wa_q.size() == 7) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit || we !== 1'b1) begin
            errors++;
            $display("FAIL arst_reach: got w=%0d we=%b want 7 1", wa_q.size(), we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({re, we, STOP} !== 3'b000 || write_addressp !== '0 ||
            read_addressp !== '0 || dp !== '0) begin
            errors++;
            $display("FAIL arst_now: got ctl=%b wa=%0d ra=%0d dp=%0d want 0",
                     {re, we, STOP}, write_addressp, read_addressp, dp);
        end
        repeat (3) @(negedge clk);
        unpool_en = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() != 7 || STOP !== 1'b0) begin
            errors++;
            $display("FAIL arst_quiet: got w=%0d STOP=%b want 7 0", wa_q.size(), STOP);
        end
        clear_log();
        run_to_stop(60, edges, to);
        checks++;
        if (to || edges != 25 || wa_q.size() != 16) begin
            errors++;
            $display("FAIL arst_rerun: got edges=%0d w=%0d want 25 16", edges, wa_q.size());
        end
        for (int i = 0; i < 16 && i < wa_q.size(); i++) begin
            checks++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                errors++;
                $display("FAIL arst_write%0d: got %0d=%0d want %0d=%0d",
                         i, wa_q[i], wd_q[i], ea[i], ed[i]);
            end
        end
        go_idle(2);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        test_reset();
        test_replicate();
        test_random();
        test_boundaries();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
